rvga_dmem_bridge: RTL and testbench

Data-memory bridge between the pipeline's memory-stage port and the on-chip data bus. It sits directly downstream of the core's dmem interface. It turns the core's level-held read/write request into a single registered bus transaction with a valid/ready request phase and a separate read-return phase. It then returns a one-cycle response pulse that releases the memory-stage stall. It also provides a bounded request-phase timeout and a sticky error flag.

---
 rtl/rvga_dmem_bridge_if.sv | 40 ++++
 rtl/rvga_dmem_bridge.sv | 107 ++++++++++
 tb/tb_rvga_dmem_bridge.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvga_dmem_bridge_if.sv
// Core memory-stage port and on-chip data bus bundle for rvga_dmem_bridge.
// slave: the bridge's view; master: the core/bus environment's view.
interface rvga_dmem_bridge_if;
  logic        core_r_v_i;
  logic        core_w_v_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_data_i;
  logic [31:0] core_data_o;
  logic        core_resp_v_o;
  logic        bus_req_v_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ready_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  modport slave (
    input  core_r_v_i, core_w_v_i,
    input  core_addr_i, core_data_i,
    output core_data_o, core_resp_v_o,
    output bus_req_v_o, bus_we_o,
    output bus_addr_o, bus_wdata_o,
    input  bus_ready_i, bus_rvalid_i,
    input  bus_rdata_i,
    output err_o
  );

  modport master (
    output core_r_v_i, core_w_v_i,
    output core_addr_i, core_data_i,
    input  core_data_o, core_resp_v_o,
    input  bus_req_v_o, bus_we_o,
    input  bus_addr_o, bus_wdata_o,
    output bus_ready_i, bus_rvalid_i,
    output bus_rdata_i,
    input  err_o
  );
endinterface

// File: rtl/rvga_dmem_bridge.sv
// Data-memory bridge: level-held core request -> one registered bus
// transaction, with request-phase timeout and sticky error flag.
module rvga_dmem_bridge #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  rvga_dmem_bridge_if.slave dm
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_CNT =
    TIMEOUT_W'(TIMEOUT);

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          data_q;
  logic                 we_q;
  logic                 req_q;
  logic                 resp_q;
  logic                 err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      // rvalid is only meaningful while a read waits for data
      if (dm.bus_rvalid_i && state != WAIT_R)
        err_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (dm.core_w_v_i || dm.core_r_v_i) begin
            addr_q  <= {dm.core_addr_i[31:2], 2'b00};
            wdata_q <= dm.core_data_i;
            we_q    <= dm.core_w_v_i;
            req_q   <= 1'b1;
            cnt     <= '0;
            state   <= REQ;
            if ((dm.core_w_v_i && dm.core_r_v_i) ||
                (dm.core_addr_i[1:0] != 2'b00))
              err_q <= 1'b1;
          end
        end
        REQ: begin
          if (dm.bus_ready_i) begin
            req_q <= 1'b0;
            if (we_q) begin
              resp_q <= 1'b1;
              state  <= RESP;
            end else begin
              state  <= WAIT_R;
            end
          end else if (TIMEOUT != 0 && cnt == TO_CNT) begin
            req_q  <= 1'b0;
            resp_q <= 1'b1;
            err_q  <= 1'b1;
            if (!we_q)
              data_q <= 32'hDEAD_BEEF;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (dm.bus_rvalid_i) begin
            data_q <= dm.bus_rdata_i;
            resp_q <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dm.core_data_o   = data_q;
  assign dm.core_resp_v_o = resp_q;
  assign dm.bus_req_v_o   = req_q;
  assign dm.bus_we_o      = we_q;
  assign dm.bus_addr_o    = addr_q;
  assign dm.bus_wdata_o   = wdata_q;
  assign dm.err_o         = err_q;

endmodule

// File: tb/tb_rvga_dmem_bridge.sv
// Directed bench for rvga_dmem_bridge: vector table plus
// hand sequences for timeout, stray rvalid and async reset.
module tb_rvga_dmem_bridge;

  logic clk_i;
  logic rst_i;

  rvga_dmem_bridge_if d ();
  rvga_dmem_bridge_if t ();

  rvga_dmem_bridge dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dm    (d.slave)
  );

  rvga_dmem_bridge #(
    .TIMEOUT   (4),
    .TIMEOUT_W (8)
  ) dut_to (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dm    (t.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          exp_lat;
    int          exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int first;
    int reqc;
    int acc;
    int resp_k;
    @(negedge clk_i);
    d.core_w_v_i  = v.w;
    d.core_r_v_i  = v.r;
    d.core_addr_i = v.addr;
    d.core_data_i = v.wdata;
    first  = -1;
    reqc   = 0;
    acc    = -1;
    resp_k = -1;
    for (int k = 1; k <= 40 && resp_k < 0; k++) begin
      @(negedge clk_i);
      d.bus_ready_i  = 1'b0;
      d.bus_rvalid_i = 1'b0;
      if (d.core_resp_v_o) begin
        resp_k = k;
      end else begin
        if (d.bus_req_v_o) begin
          if (first < 0) first = k;
          reqc++;
          chk({tag, "_addr"}, d.bus_addr_o, v.exp_addr);
          chk({tag, "_we"}, 32'(d.bus_we_o), 32'(v.exp_we));
          if (v.w)
            chk({tag, "_wdata"}, d.bus_wdata_o, v.wdata);
          if (reqc - 1 == v.rdy_dly) begin
            d.bus_ready_i = 1'b1;
            acc = k;
          end
        end
        if (!v.w && acc >= 0 && k == acc + 1 + v.rv_dly) begin
          d.bus_rvalid_i = 1'b1;
          d.bus_rdata_i  = v.rdata;
        end
      end
    end
    d.core_w_v_i   = 1'b0;
    d.core_r_v_i   = 1'b0;
    d.bus_ready_i  = 1'b0;
    d.bus_rvalid_i = 1'b0;
    chk({tag, "_first_req"}, 32'(first), 32'd1);
    chk({tag, "_lat"}, 32'(resp_k), 32'(v.exp_lat));
    chk({tag, "_req_cycles"}, 32'(reqc), 32'(v.exp_req));
    chk({tag, "_data"}, d.core_data_o, v.exp_data);
    chk({tag, "_err"}, 32'(d.err_o), 32'(v.exp_err));
    @(negedge clk_i);
    chk({tag, "_resp_pulse"}, 32'(d.core_resp_v_o), 32'd0);
  endtask

  task automatic to_txn(input logic w,
                        input logic [31:0] addr,
                        input int rdy_k,
                        input logic [31:0] rdata,
                        output int reqc,
                        output int resp_k);
    @(negedge clk_i);
    t.core_w_v_i  = w;
    t.core_r_v_i  = !w;
    t.core_addr_i = addr;
    t.core_data_i = 32'h0000_00FF;
    reqc   = 0;
    resp_k = -1;
    for (int k = 1; k <= 40 && resp_k < 0; k++) begin
      @(negedge clk_i);
      t.bus_ready_i  = 1'b0;
      t.bus_rvalid_i = 1'b0;
      if (t.core_resp_v_o) begin
        resp_k = k;
      end else begin
        if (t.bus_req_v_o) begin
          reqc++;
          if (k == rdy_k) t.bus_ready_i = 1'b1;
        end
        if (!w && rdy_k > 0 && k == rdy_k + 1) begin
          t.bus_rvalid_i = 1'b1;
          t.bus_rdata_i  = rdata;
        end
      end
    end
    t.core_w_v_i   = 1'b0;
    t.core_r_v_i   = 1'b0;
    t.bus_ready_i  = 1'b0;
    t.bus_rvalid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rq;
    int rk;
    vec_t sv;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h1234_5678, 0, 0,
                32'h0, 2, 1, 32'h100, 1'b1, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h100, 32'h0, 0, 0,
                32'h1234_5678, 3, 1, 32'h100, 1'b0,
                32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h200, 32'h0, 5, 0,
                32'hCAFE_F00D, 8, 6, 32'h200, 1'b0,
                32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h204, 32'h55, 2, 0,
                32'h0, 4, 3, 32'h204, 1'b1,
                32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h208, 32'h0, 1, 3,
                32'h0BAD_C0DE, 7, 2, 32'h208, 1'b0,
                32'h0BAD_C0DE, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h103, 32'h77, 0, 0,
                32'h0, 2, 1, 32'h100, 1'b1,
                32'h0BAD_C0DE, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h10A, 32'h0, 0, 0,
                32'h1122_3344, 3, 1, 32'h108, 1'b0,
                32'h1122_3344, 1'b1};

    rst_i = 1'b1;
    d.core_r_v_i = 0; d.core_w_v_i = 0;
    d.core_addr_i = 0; d.core_data_i = 0;
    d.bus_ready_i = 0; d.bus_rvalid_i = 0;
    d.bus_rdata_i = 0;
    t.core_r_v_i = 0; t.core_w_v_i = 0;
    t.core_addr_i = 0; t.core_data_i = 0;
    t.bus_ready_i = 0; t.bus_rvalid_i = 0;
    t.bus_rdata_i = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", 32'(d.bus_req_v_o), 32'd0);
    chk("rst_we", 32'(d.bus_we_o), 32'd0);
    chk("rst_resp", 32'(d.core_resp_v_o), 32'd0);
    chk("rst_err", 32'(d.err_o), 32'd0);
    chk("rst_data", d.core_data_o, 32'd0);
    chk("rst_addr", d.bus_addr_o, 32'd0);
    chk("rst_wdata", d.bus_wdata_o, 32'd0);
    chk("rst_to_req", 32'(t.bus_req_v_o), 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++)
      do_txn(vecs[i], $sformatf("v%0d", i));

    // stray rvalid in IDLE
    pulse_reset();
    sv = '{1'b0, 1'b1, 32'h40, 32'h0, 0, 0, 32'h5A5A_5A5A,
           3, 1, 32'h40, 1'b0, 32'h5A5A_5A5A, 1'b0};
    do_txn(sv, "stray_pre");
    @(negedge clk_i);
    d.bus_rvalid_i = 1'b1;
    d.bus_rdata_i  = 32'hAAAA_AAAA;
    @(negedge clk_i);
    d.bus_rvalid_i = 1'b0;
    chk("stray_resp", 32'(d.core_resp_v_o), 32'd0);
    chk("stray_data", d.core_data_o, 32'h5A5A_5A5A);
    chk("stray_err", 32'(d.err_o), 32'd1);
    @(negedge clk_i);
    chk("stray_resp2", 32'(d.core_resp_v_o), 32'd0);

    // reset while waiting for read data
    pulse_reset();
    sv = '{1'b0, 1'b1, 32'h44, 32'h0, 0, 0, 32'h1357_9BDF,
           3, 1, 32'h44, 1'b0, 32'h1357_9BDF, 1'b0};
    do_txn(sv, "mid_pre");
    @(negedge clk_i);
    d.core_r_v_i  = 1'b1;
    d.core_addr_i = 32'h300;
    @(negedge clk_i);
    chk("mid_req", 32'(d.bus_req_v_o), 32'd1);
    d.bus_ready_i = 1'b1;
    @(negedge clk_i);
    d.bus_ready_i = 1'b0;
    chk("mid_waitr_req", 32'(d.bus_req_v_o), 32'd0);
    chk("mid_waitr_addr", d.bus_addr_o, 32'h300);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_addr", d.bus_addr_o, 32'd0);
    chk("mid_rst_data", d.core_data_o, 32'd0);
    chk("mid_rst_resp", 32'(d.core_resp_v_o), 32'd0);
    chk("mid_rst_err", 32'(d.err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    d.core_r_v_i = 1'b0;
    @(negedge clk_i);
    d.bus_rvalid_i = 1'b1;
    d.bus_rdata_i  = 32'hFFFF_0000;
    @(negedge clk_i);
    d.bus_rvalid_i = 1'b0;
    chk("late_rv_resp", 32'(d.core_resp_v_o), 32'd0);
    chk("late_rv_data", d.core_data_o, 32'd0);
    chk("late_rv_err", 32'(d.err_o), 32'd1);
    sv = '{1'b0, 1'b1, 32'h300, 32'h0, 0, 0, 32'h600D_F00D,
           3, 1, 32'h300, 1'b0, 32'h600D_F00D, 1'b1};
    do_txn(sv, "mid_post");

    // timeout instance, TIMEOUT = 4
    pulse_reset();
    to_txn(1'b0, 32'h60, 5, 32'h0A0B_0C0D, rq, rk);
    chk("race_req_cycles", 32'(rq), 32'd5);
    chk("race_lat", 32'(rk), 32'd7);
    chk("race_data", t.core_data_o, 32'h0A0B_0C0D);
    chk("race_err", 32'(t.err_o), 32'd0);
    to_txn(1'b0, 32'h64, 0, 32'h0, rq, rk);
    chk("to_rd_req_cycles", 32'(rq), 32'd5);
    chk("to_rd_lat", 32'(rk), 32'd6);
    chk("to_rd_data", t.core_data_o, 32'hDEAD_BEEF);
    chk("to_rd_err", 32'(t.err_o), 32'd1);
    chk("to_rd_req_low", 32'(t.bus_req_v_o), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("to_err_sticky", 32'(t.err_o), 32'd1);
    to_txn(1'b1, 32'h68, 0, 32'h0, rq, rk);
    chk("to_wr_lat", 32'(rk), 32'd6);
    chk("to_wr_data", t.core_data_o, 32'hDEAD_BEEF);

    // asynchronous drop of bus_req_v_o
    @(negedge clk_i);
    t.core_r_v_i  = 1'b1;
    t.core_addr_i = 32'h50;
    @(negedge clk_i);
    chk("async_req_hi", 32'(t.bus_req_v_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_req_lo", 32'(t.bus_req_v_o), 32'd0);
    chk("async_err", 32'(t.err_o), 32'd0);
    chk("async_addr", t.bus_addr_o, 32'd0);
    chk("async_data", t.core_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    t.core_r_v_i = 1'b0;
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
